// File: rtl/ram_stream_pkg.sv
// Package for ram_stream_ctrl.
// Holds the controller state encoding, default address/data widths and the
// helper that turns an address width into a sweep depth.
package ram_stream_pkg;

  localparam int unsigned AW_DEFAULT = 4;
  localparam int unsigned DW_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RD_ADDR,
    RD_OUT,
    DONE
  } rsc_state_t;

  // Number of words covered by one FILL or DUMP sweep.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ram_stream_ctrl.sv
// ram_stream_ctrl: upstream controller for a small synchronous DFF RAM.
//   FILL: writes a valid/ready input stream to RAM addresses 0..DEPTH-1.
//   DUMP: reads RAM addresses 0..DEPTH-1 out as a valid/ready stream,
//         absorbing the RAM's one-cycle read latency.
// Optional feature macro: RAM_STREAM_CTRL_CSUM_EN adds a running XOR checksum
// output (csum) of every transferred word.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   cmd_start, cmd_write      start command (1 = FILL, 0 = DUMP), sampled in IDLE
//   busy, done                status; done is a one-cycle completion pulse
//   s_valid/s_ready/s_data    FILL input stream
//   m_valid/m_ready/m_data    DUMP output stream, m_last flags address DEPTH-1
//   mem_addr/mem_data/mem_wren  RAM write/address pins
//   mem_q                     RAM read data (valid one cycle after the address)
//   csum                      (feature build only) running XOR checksum
module ram_stream_ctrl
  import ram_stream_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_start,
  input  logic          cmd_write,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
`ifdef RAM_STREAM_CTRL_CSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  localparam logic [AW-1:0] LastAddr = AW'(depth_of(AW) - 1);

  rsc_state_t    r_state, w_state_d;
  logic [AW-1:0] r_cnt, w_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // The counter doubles as the RAM address in every state, so during RD_OUT
  // the RAM keeps re-reading the same word and m_data stays stable.
  assign mem_addr = r_cnt;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    busy      = 1'b1;
    done      = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_data    = '0;
    mem_data  = '0;
    mem_wren  = 1'b0;

    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (cmd_start) begin
          w_cnt_d   = '0;
          w_state_d = cmd_write ? FILL : RD_ADDR;
        end
      end

      FILL: begin
        s_ready  = 1'b1;
        mem_wren = s_valid;
        mem_data = s_data;
        if (s_valid) begin
          if (r_cnt == LastAddr) begin
            w_state_d = DONE;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end

      // Address presented this cycle; RAM data is available in RD_OUT.
      RD_ADDR: begin
        w_state_d = RD_OUT;
      end

      RD_OUT: begin
        m_valid = 1'b1;
        m_data  = mem_q;
        m_last  = (r_cnt == LastAddr);
        if (m_ready) begin
          if (r_cnt == LastAddr) begin
            w_state_d = DONE;
          end else begin
            w_cnt_d   = r_cnt + 1'b1;
            w_state_d = RD_ADDR;
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        w_state_d = IDLE;
      end

      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

`ifdef RAM_STREAM_CTRL_CSUM_EN
  logic [DW-1:0] r_csum, w_csum_d;

  // Cleared by an accepted start, accumulates accepted beats, and simply holds
  // in DONE/IDLE until the next start.
  always_comb begin
    w_csum_d = r_csum;
    if (r_state == IDLE && cmd_start) begin
      w_csum_d = '0;
    end else if (r_state == FILL && s_valid) begin
      w_csum_d = r_csum ^ s_data;
    end else if (r_state == RD_OUT && m_ready) begin
      w_csum_d = r_csum ^ mem_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else begin
      r_csum <= w_csum_d;
    end
  end

  assign csum = r_csum;
`endif

endmodule
